// File: rtl/ring_freq_counter.sv
// Gated rising-edge counter for one ring-oscillator tap. Counts synchronized
// rising edges of the selected tap over a gate window measured in clk cycles.
module ring_freq_counter #(
    parameter int COUNT_WIDTH   = 24,
    parameter int GATE_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             osc_taps,
    input  logic [2:0]             tap_sel,
    input  logic [GATE_WIDTH-1:0]  gate_len,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] result,
    output logic                   overflow,
    input  logic [1:0]             byte_sel,
    output logic [7:0]             result_byte
);

    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t                 r_state;
    logic [2:0]             r_sel;
    logic [GATE_WIDTH-1:0]  r_gate;
    logic [GATE_WIDTH-1:0]  r_gate_cnt;
    logic [SW-1:0]          r_settle;
    logic                   r_s1, r_s2, r_s3;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] r_result;
    logic                   r_ovf;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_tap;
    logic                   w_rise;
    logic [COUNT_WIDTH-1:0] w_cnt_next;
    logic [31:0]            w_res32;

    assign w_tap  = osc_taps[r_sel];
    assign w_rise = r_s2 & ~r_s3;

    // Count only inside the gate; hold at all-ones instead of wrapping.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_state == MEASURE && w_rise && r_cnt != CNT_MAX)
            w_cnt_next = r_cnt + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= w_tap;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_gate     <= '0;
            r_gate_cnt <= '0;
            r_settle   <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_cnt_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sel    <= tap_sel;
                        r_gate   <= gate_len;
                        r_cnt    <= '0;
                        r_settle <= SW'(SETTLE_CYCLES - 1);
                        r_busy   <= 1'b1;
                        r_state  <= ARM;
                    end
                end
                ARM: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - SW'(1);
                    end else if (r_gate != '0) begin
                        r_gate_cnt <= r_gate - GATE_WIDTH'(1);
                        r_state    <= MEASURE;
                    end else begin
                        r_result <= w_cnt_next;
                        r_ovf    <= (w_cnt_next == CNT_MAX);
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                MEASURE: begin
                    if (r_gate_cnt != '0) begin
                        r_gate_cnt <= r_gate_cnt - GATE_WIDTH'(1);
                    end else begin
                        // Final gate cycle's edge is folded in via w_cnt_next.
                        r_result <= w_cnt_next;
                        r_ovf    <= (w_cnt_next == CNT_MAX);
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_res32 = '0;
        w_res32[COUNT_WIDTH-1:0] = r_result;
    end

    assign result_byte = w_res32[{byte_sel, 3'b000} +: 8];
    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign overflow    = r_ovf;

endmodule
